// File: rtl/inner_product_engine_pkg.sv
// Shared definitions for the inner-product engine: FSM encoding and memory word geometry.
package inner_product_engine_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        MAC  = 3'd3,
        FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/inner_product_engine_if.sv
// Job request/response and word-memory read port of the inner-product engine.
interface inner_product_engine_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 2 * DATA_W + LEN_W
);
    logic              start;
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [LEN_W-1:0]  len;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  result;
    logic              overflow;

    // master: the requester that also owns the memory; slave: the engine
    modport master (
        output start, base_a, base_b, len, mem_rdata,
        input  mem_rd_en, mem_addr, busy, done, result, overflow
    );

    modport slave (
        input  start, base_a, base_b, len, mem_rdata,
        output mem_rd_en, mem_addr, busy, done, result, overflow
    );

endinterface

// File: rtl/inner_product_engine_mac_unit.sv
// Combinational multiply-accumulate: full-width product, extension to the
// accumulator width and add-overflow detection for signed or unsigned operands.
module mac_unit
    import inner_product_engine_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ACC_W       = 72,
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  acc_out,
    output logic              overflow
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    generate
        if (SIGNED_MODE) begin : g_signed
            logic signed [2*DATA_W-1:0] a_ext;
            logic signed [2*DATA_W-1:0] b_ext;

            assign a_ext    = (2*DATA_W)'($signed(a));
            assign b_ext    = (2*DATA_W)'($signed(b));
            assign prod     = a_ext * b_ext;
            assign prod_ext = ACC_W'($signed(prod));
            assign acc_out  = acc_in + prod_ext;
            // two same-signed addends producing the opposite sign means the sum left the range
            assign overflow = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
                              (acc_out[ACC_W-1] != acc_in[ACC_W-1]);
        end else begin : g_unsigned
            logic [2*DATA_W-1:0] a_ext;
            logic [2*DATA_W-1:0] b_ext;
            logic                carry;

            assign a_ext              = (2*DATA_W)'(a);
            assign b_ext              = (2*DATA_W)'(b);
            assign prod               = a_ext * b_ext;
            assign prod_ext           = ACC_W'(prod);
            assign {carry, acc_out}   = {1'b0, acc_in} + {1'b0, prod_ext};
            assign overflow           = carry;
        end
    endgenerate

endmodule

// File: rtl/inner_product_engine.sv
// Sequential dot-product engine: walks two word vectors in memory, one read per
// operand, accumulating the products and reporting the sum with a sticky overflow.
module inner_product_engine
    import inner_product_engine_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LEN_W       = 8,
    parameter int ACC_W       = 2 * DATA_W + LEN_W,
    parameter bit SIGNED_MODE = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    inner_product_engine_if.slave bus
);

    state_t            state_reg;
    logic [ADDR_W-1:0] base_a_reg;
    logic [ADDR_W-1:0] base_b_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  index_reg;
    logic [DATA_W-1:0] opa_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [ACC_W-1:0]  result_reg;
    logic              ovf_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              rd_en_reg;
    logic [ADDR_W-1:0] addr_reg;

    logic [LEN_W-1:0]  index_next;
    logic [ADDR_W-1:0] off_cur;
    logic [ADDR_W-1:0] off_next;
    logic              last_elem;
    logic [ACC_W-1:0]  acc_next;
    logic              acc_ovf;

    assign index_next = index_reg + LEN_W'(1);
    assign off_cur    = ADDR_W'(index_reg) * ADDR_W'(WORD_BYTES);
    assign off_next   = ADDR_W'(index_next) * ADDR_W'(WORD_BYTES);
    assign last_elem  = (index_next == len_reg);

    // operand A was captured during the B read; B arrives on mem_rdata in MAC
    mac_unit #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .SIGNED_MODE (SIGNED_MODE)
    ) u_mac (
        .a        (opa_reg),
        .b        (bus.mem_rdata),
        .acc_in   (acc_reg),
        .acc_out  (acc_next),
        .overflow (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            base_a_reg <= '0;
            base_b_reg <= '0;
            len_reg    <= '0;
            index_reg  <= '0;
            opa_reg    <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            rd_en_reg  <= 1'b0;
            addr_reg   <= '0;
        end else begin
            // read strobe, address and done are one-cycle outputs unless re-armed below
            done_reg  <= 1'b0;
            rd_en_reg <= 1'b0;
            addr_reg  <= '0;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        busy_reg  <= 1'b1;
                        acc_reg   <= '0;
                        index_reg <= '0;
                        ovf_reg   <= 1'b0;
                        if (bus.len != '0) begin
                            base_a_reg <= bus.base_a;
                            base_b_reg <= bus.base_b;
                            len_reg    <= bus.len;
                            rd_en_reg  <= 1'b1;
                            addr_reg   <= bus.base_a;
                            state_reg  <= RD_A;
                        end else begin
                            result_reg <= '0;
                            done_reg   <= 1'b1;
                            state_reg  <= FIN;
                        end
                    end
                end

                RD_A: begin
                    rd_en_reg <= 1'b1;
                    addr_reg  <= base_b_reg + off_cur;
                    state_reg <= RD_B;
                end

                RD_B: begin
                    opa_reg   <= bus.mem_rdata;
                    state_reg <= MAC;
                end

                MAC: begin
                    acc_reg   <= acc_next;
                    ovf_reg   <= ovf_reg | acc_ovf;
                    index_reg <= index_next;
                    if (last_elem) begin
                        result_reg <= acc_next;
                        done_reg   <= 1'b1;
                        state_reg  <= FIN;
                    end else begin
                        rd_en_reg <= 1'b1;
                        addr_reg  <= base_a_reg + off_next;
                        state_reg <= RD_A;
                    end
                end

                FIN: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en = rd_en_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.result    = result_reg;
    assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_inner_product_engine.sv
// Directed bench for the inner-product engine: two instances (32-bit signed, 8-bit unsigned)
// with a scoreboard queue per instance checked by done-driven monitors.
module tb_inner_product_engine;
    import inner_product_engine_pkg::*;

    localparam int DW0  = 32;
    localparam int DW1  = 8;
    localparam int AW   = 32;
    localparam int LW   = 8;
    localparam int ACC0 = 2 * DW0 + LW;
    localparam int ACC1 = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inner_product_engine_if #(.DATA_W(DW0), .ADDR_W(AW), .LEN_W(LW), .ACC_W(ACC0)) bus0 ();
    inner_product_engine_if #(.DATA_W(DW1), .ADDR_W(AW), .LEN_W(LW), .ACC_W(ACC1)) bus1 ();

    inner_product_engine #(
        .DATA_W(DW0), .ADDR_W(AW), .LEN_W(LW), .ACC_W(ACC0), .SIGNED_MODE(1'b1)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    inner_product_engine #(
        .DATA_W(DW1), .ADDR_W(AW), .LEN_W(LW), .ACC_W(ACC1), .SIGNED_MODE(1'b0)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    // word memories with one-cycle registered read
    logic [DW0-1:0] mem0 [64];
    logic [DW1-1:0] mem1 [64];

    always @(posedge clk) begin
        if (bus0.mem_rd_en) bus0.mem_rdata <= mem0[bus0.mem_addr[7:2]];
        if (bus1.mem_rd_en) bus1.mem_rdata <= mem1[bus1.mem_addr[7:2]];
    end

    typedef struct {
        logic [ACC0-1:0] result;
        logic            ovf;
        int              start_cyc;
        int              latency;
        int              rd_cnt;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0;
    exp_t e1;
    int   n_vec = 0;
    int   n_err = 0;
    int   rd0 = 0, rd1 = 0;
    int   done_cnt0 = 0;
    logic abad0 = 1'b0, abad1 = 1'b0;

    task automatic check(input string name, input logic [ACC0-1:0] got, input logic [ACC0-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic score(input int d, input exp_t e, input logic [ACC0-1:0] res, input logic ovf,
                         input logic busy, input int rd, input logic abad);
        $display("dut%0d job: result=0x%0h overflow=%0d latency=%0d reads=%0d",
                 d, res, ovf, cyc - e.start_cyc, rd);
        check("result", res, e.result);
        check("overflow", ACC0'(ovf), ACC0'(e.ovf));
        check("latency", ACC0'(cyc - e.start_cyc), ACC0'(e.latency));
        check("busy at done", ACC0'(busy), ACC0'(1));
        check("read count", ACC0'(rd), ACC0'(e.rd_cnt));
        check("addr zero when idle strobe", ACC0'(abad), ACC0'(0));
    endtask

    always @(negedge clk) begin
        if (reset) begin
            rd0   = 0;
            abad0 = 1'b0;
        end else begin
            if (bus0.mem_rd_en) rd0++;
            else if (bus0.mem_addr != '0) abad0 = 1'b1;
            if (bus0.done) begin
                done_cnt0++;
                if (q0.size() == 0) begin
                    check("dut0 unexpected done", ACC0'(bus0.done), ACC0'(0));
                end else begin
                    e0 = q0.pop_front();
                    score(0, e0, bus0.result, bus0.overflow, bus0.busy, rd0, abad0);
                end
                rd0   = 0;
                abad0 = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            rd1   = 0;
            abad1 = 1'b0;
        end else begin
            if (bus1.mem_rd_en) rd1++;
            else if (bus1.mem_addr != '0) abad1 = 1'b1;
            if (bus1.done) begin
                if (q1.size() == 0) begin
                    check("dut1 unexpected done", ACC0'(bus1.done), ACC0'(0));
                end else begin
                    e1 = q1.pop_front();
                    score(1, e1, ACC0'(bus1.result), bus1.overflow, bus1.busy, rd1, abad1);
                end
                rd1   = 0;
                abad1 = 1'b0;
            end
        end
    end

    function automatic logic busy_of(input int d);
        return (d == 0) ? bus0.busy : bus1.busy;
    endfunction

    // all driver tasks are entered and left 1 time unit after a rising edge
    task automatic issue(input int d, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [LW-1:0] n, input logic [ACC0-1:0] res, input logic ovf,
                         input bit expect_done);
        exp_t e;
        if (d == 0) begin
            bus0.start = 1'b1; bus0.base_a = a; bus0.base_b = b; bus0.len = n;
        end else begin
            bus1.start = 1'b1; bus1.base_a = a; bus1.base_b = b; bus1.len = n;
        end
        e.result    = res;
        e.ovf       = ovf;
        e.start_cyc = cyc;
        e.latency   = 3 * int'(n) + 1;
        e.rd_cnt    = 2 * int'(n);
        if (expect_done) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic drop_start(input int d);
        if (d == 0) bus0.start = 1'b0;
        else        bus1.start = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int max_cyc);
        int k = 0;
        while (busy_of(d) && k < max_cyc) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= max_cyc) check("idle timeout busy", ACC0'(busy_of(d)), ACC0'(0));
    endtask

    task automatic run_job(input int d, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [LW-1:0] n, input logic [ACC0-1:0] res, input logic ovf);
        issue(d, a, b, n, res, ovf, 1'b1);
        @(posedge clk); #1;
        drop_start(d);
        check("busy after start", ACC0'(busy_of(d)), ACC0'(1));
        wait_idle(d, 3 * int'(n) + 10);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion well before %0t", $time);
        $fatal(1);
    end

    initial begin
        int k;
        int snap;

        for (int i = 0; i < 64; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[0] = 32'd1; mem0[1] = 32'd2; mem0[2] = 32'd3; mem0[3] = 32'd4;
        mem0[4] = 32'd5; mem0[5] = 32'd6; mem0[6] = 32'd7; mem0[7] = 32'd8;
        mem0[8] = 32'd3; mem0[9] = 32'd10; mem0[63] = 32'd7;
        mem0[16] = -32'sd3; mem0[17] = 32'd2;
        mem0[32] = 32'd4;   mem0[33] = -32'sd5;
        mem1[0] = 8'd255; mem1[1] = 8'd255; mem1[2] = 8'd255; mem1[3] = 8'd255;
        mem1[4] = 8'd3;   mem1[5] = 8'd4;   mem1[6] = 8'd5;   mem1[7] = 8'd6;

        bus0.start = 1'b0; bus0.base_a = '0; bus0.base_b = '0; bus0.len = '0;
        bus1.start = 1'b0; bus1.base_a = '0; bus1.base_b = '0; bus1.len = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset busy", ACC0'(bus0.busy), ACC0'(0));
        check("reset done", ACC0'(bus0.done), ACC0'(0));
        check("reset mem_rd_en", ACC0'(bus0.mem_rd_en), ACC0'(0));
        check("reset mem_addr", ACC0'(bus0.mem_addr), ACC0'(0));
        check("reset result", bus0.result, ACC0'(0));
        check("reset overflow", ACC0'(bus0.overflow), ACC0'(0));
        check("dut1 reset outputs",
              ACC0'({bus1.busy, bus1.done, bus1.mem_rd_en, bus1.mem_addr, bus1.result, bus1.overflow}),
              ACC0'(0));

        // basic, back-to-back signed, empty, address wrap, single element
        run_job(0, 32'h0000_0000, 32'h0000_0010, 8'd4, ACC0'(70), 1'b0);
        run_job(0, 32'h0000_0040, 32'h0000_0080, 8'd2, -ACC0'(22), 1'b0);
        run_job(0, 32'h0000_0100, 32'h0000_0200, 8'd0, ACC0'(0), 1'b0);
        run_job(0, 32'hFFFF_FFFC, 32'h0000_0020, 8'd2, ACC0'(31), 1'b0);
        run_job(0, 32'h0000_0040, 32'h0000_0080, 8'd1, -ACC0'(12), 1'b0);

        // start held with a different job through busy and the done cycle: ignored
        issue(0, 32'h0000_0000, 32'h0000_0010, 8'd4, ACC0'(70), 1'b0, 1'b1);
        @(posedge clk); #1;
        bus0.len = 8'd2; bus0.base_a = 32'h40; bus0.base_b = 32'h80;
        k = 0;
        while (!bus0.done && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 30) check("held-start done timeout", ACC0'(bus0.done), ACC0'(1));
        @(posedge clk); #1;
        drop_start(0);
        repeat (10) @(posedge clk);
        #1;
        check("held-start no second job", ACC0'(bus0.busy), ACC0'(0));

        // reset during MAC of element index 2 aborts the job silently
        snap = done_cnt0;
        issue(0, 32'h0000_0000, 32'h0000_0010, 8'd4, ACC0'(70), 1'b0, 1'b0);
        @(posedge clk); #1;
        drop_start(0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort busy", ACC0'(bus0.busy), ACC0'(0));
        check("abort done", ACC0'(bus0.done), ACC0'(0));
        check("abort mem_rd_en", ACC0'(bus0.mem_rd_en), ACC0'(0));
        check("abort mem_addr", ACC0'(bus0.mem_addr), ACC0'(0));
        check("abort result", bus0.result, ACC0'(0));
        check("abort overflow", ACC0'(bus0.overflow), ACC0'(0));
        repeat (15) @(posedge clk);
        #1;
        check("abort no done pulse", ACC0'(done_cnt0), ACC0'(snap));
        run_job(0, 32'h0000_0000, 32'h0000_0010, 8'd4, ACC0'(70), 1'b0);

        // narrow unsigned instance: wrapped overflow, then overflow cleared by the next job
        run_job(1, 32'h0000_0000, 32'h0000_0008, 8'd2, ACC0'(16'hFC02), 1'b1);
        run_job(1, 32'h0000_0010, 32'h0000_0018, 8'd2, ACC0'(39), 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("dut0 pending jobs", ACC0'(q0.size()), ACC0'(0));
        check("dut1 pending jobs", ACC0'(q1.size()), ACC0'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
